// File: rtl/hawk_pkg.sv
// Shared constants and state encoding for the sector read path.
package hawk_pkg;

    localparam int unsigned SECTOR_ADDR_W = 9;
    localparam int unsigned BITS_PER_BYTE = 8;

    typedef enum logic [1:0] {
        IDLE,
        FETCH0,
        RUN,
        DONE
    } read_state_t;

endpackage

// File: rtl/piso_byte.sv
// 8-bit parallel-in/serial-out shifter; load wins over shift, MSB leaves first.
module piso_byte
    import hawk_pkg::*;
(
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_load,
    input  logic                     i_shift,
    input  logic [BITS_PER_BYTE-1:0] i_data,
    output logic                     o_msb
);

    logic [BITS_PER_BYTE-1:0] r_sh;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sh <= '0;
        end else if (i_load) begin
            r_sh <= i_data;
        end else if (i_shift) begin
            r_sh <= {r_sh[BITS_PER_BYTE-2:0], 1'b0};
        end
    end

    assign o_msb = r_sh[BITS_PER_BYTE-1];

endmodule

// File: rtl/sector_read.sv
// Sector read serializer: fetches buffer bytes and shifts them MSB-first onto
// the read-data line, one bit per bit-cell strobe, flagging underruns.
module sector_read
    import hawk_pkg::*;
#(
    parameter int unsigned ADDR_W   = SECTOR_ADDR_W,
    parameter int unsigned RD_LAT   = 1,
    parameter logic        IDLE_BIT = 1'b0
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     bit_tick,
    input  logic                     data_area,
    input  logic [BITS_PER_BYTE-1:0] rd_data,
    output logic [ADDR_W-1:0]        rd_addr,
    output logic                     rd_en,
    output logic                     rd_bit,
    output logic                     underrun,
    output logic                     done
);

    localparam int unsigned CNT_W = ADDR_W + 3;

    read_state_t              r_state, w_state_nxt;
    logic [CNT_W-1:0]         r_bit_count, w_bit_count_nxt;
    logic [2:0]               r_sh_cnt, w_sh_cnt_nxt;
    logic [ADDR_W-1:0]        r_rd_addr, w_rd_addr_nxt;
    logic                     r_rd_en, w_rd_en_nxt;
    logic                     r_rd_bit, w_rd_bit_nxt;
    logic                     r_underrun, w_underrun_nxt;
    logic                     r_done, w_done_nxt;
    logic                     r_sh_valid, w_sh_valid_nxt;
    logic                     r_nb_valid, w_nb_valid_nxt;
    logic [BITS_PER_BYTE-1:0] r_nb, w_nb_nxt;
    logic [RD_LAT-1:0]        r_pipe, w_pipe_nxt;

    logic                     w_ret;
    logic                     w_sh_load;
    logic                     w_sh_shift;
    logic                     w_sh_msb;
    logic [BITS_PER_BYTE-1:0] w_sh_data;
    logic [ADDR_W-1:0]        w_byte_idx;

    assign w_ret      = r_pipe[RD_LAT-1];
    assign w_byte_idx = r_bit_count[CNT_W-1:3];

    piso_byte u_piso (
        .clk     (clk),
        .rst     (rst),
        .i_load  (w_sh_load),
        .i_shift (w_sh_shift),
        .i_data  (w_sh_data),
        .o_msb   (w_sh_msb)
    );

    // r_sh_cnt tracks bits consumed from the shifter; it lags r_bit_count when
    // a tick landed before the first byte arrived, shifting the whole stream.
    always_comb begin
        w_state_nxt     = r_state;
        w_bit_count_nxt = r_bit_count;
        w_sh_cnt_nxt    = r_sh_cnt;
        w_rd_addr_nxt   = r_rd_addr;
        w_rd_en_nxt     = 1'b0;
        w_rd_bit_nxt    = r_rd_bit;
        w_underrun_nxt  = r_underrun;
        w_done_nxt      = r_done;
        w_sh_valid_nxt  = r_sh_valid;
        w_nb_valid_nxt  = r_nb_valid;
        w_nb_nxt        = r_nb;
        w_pipe_nxt      = (r_pipe << 1) | RD_LAT'(r_rd_en);
        w_sh_load       = 1'b0;
        w_sh_shift      = 1'b0;
        w_sh_data       = rd_data;

        if (!data_area) begin
            w_state_nxt     = IDLE;
            w_bit_count_nxt = '0;
            w_sh_cnt_nxt    = '0;
            w_rd_addr_nxt   = '0;
            w_rd_bit_nxt    = IDLE_BIT;
            w_sh_valid_nxt  = 1'b0;
            w_nb_valid_nxt  = 1'b0;
            w_pipe_nxt      = '0;
        end else begin
            unique case (r_state)
                IDLE: begin
                    w_state_nxt     = FETCH0;
                    w_rd_en_nxt     = 1'b1;
                    w_rd_addr_nxt   = '0;
                    w_rd_bit_nxt    = IDLE_BIT;
                    w_done_nxt      = 1'b0;
                    w_underrun_nxt  = bit_tick;
                    w_bit_count_nxt = bit_tick ? CNT_W'(1) : '0;
                    w_sh_cnt_nxt    = '0;
                end
                FETCH0: begin
                    if (bit_tick) begin
                        w_rd_bit_nxt    = IDLE_BIT;
                        w_underrun_nxt  = 1'b1;
                        w_bit_count_nxt = r_bit_count + 1'b1;
                    end
                    if (w_ret) begin
                        w_sh_load      = 1'b1;
                        w_sh_data      = rd_data;
                        w_sh_valid_nxt = 1'b1;
                        w_sh_cnt_nxt   = '0;
                        w_state_nxt    = RUN;
                    end
                end
                RUN: begin
                    if (w_ret) begin
                        w_nb_nxt       = rd_data;
                        w_nb_valid_nxt = 1'b1;
                    end
                    if (bit_tick) begin
                        w_rd_bit_nxt    = r_sh_valid ? w_sh_msb : IDLE_BIT;
                        w_underrun_nxt  = r_underrun | ~r_sh_valid;
                        w_bit_count_nxt = r_bit_count + 1'b1;
                        w_sh_cnt_nxt    = r_sh_cnt + 3'd1;
                        if (r_sh_cnt == 3'd0 && w_byte_idx != '1) begin
                            w_rd_en_nxt   = 1'b1;
                            w_rd_addr_nxt = w_byte_idx + 1'b1;
                        end
                        // Byte boundary: anything still in flight is too late.
                        if (r_sh_cnt == 3'd7) begin
                            w_sh_load      = r_nb_valid;
                            w_sh_data      = r_nb;
                            w_sh_valid_nxt = r_nb_valid;
                            w_nb_valid_nxt = 1'b0;
                            w_pipe_nxt     = '0;
                        end else begin
                            w_sh_shift = 1'b1;
                        end
                        if (r_bit_count == '1) begin
                            w_state_nxt = DONE;
                            w_done_nxt  = 1'b1;
                        end
                    end
                end
                DONE: begin
                    w_rd_bit_nxt = IDLE_BIT;
                    w_done_nxt   = 1'b1;
                end
                default: w_state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_bit_count <= '0;
            r_sh_cnt    <= '0;
            r_rd_addr   <= '0;
            r_rd_en     <= 1'b0;
            r_rd_bit    <= IDLE_BIT;
            r_underrun  <= 1'b0;
            r_done      <= 1'b0;
            r_sh_valid  <= 1'b0;
            r_nb_valid  <= 1'b0;
            r_nb        <= '0;
            r_pipe      <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_bit_count <= w_bit_count_nxt;
            r_sh_cnt    <= w_sh_cnt_nxt;
            r_rd_addr   <= w_rd_addr_nxt;
            r_rd_en     <= w_rd_en_nxt;
            r_rd_bit    <= w_rd_bit_nxt;
            r_underrun  <= w_underrun_nxt;
            r_done      <= w_done_nxt;
            r_sh_valid  <= w_sh_valid_nxt;
            r_nb_valid  <= w_nb_valid_nxt;
            r_nb        <= w_nb_nxt;
            r_pipe      <= w_pipe_nxt;
        end
    end

    assign rd_addr  = r_rd_addr;
    assign rd_en    = r_rd_en;
    assign rd_bit   = r_rd_bit;
    assign underrun = r_underrun;
    assign done     = r_done;

endmodule
